// File: rtl/qracc_pkg.sv
// rtl/qracc_pkg.sv - shared QRAcc types, arbiter defaults and round-robin helper
package qracc_pkg;

  localparam int numChannels    = 4;
  localparam int numRows        = 128;
  localparam int numCols        = 32;
  localparam int maxOutstanding = 4;

  typedef logic [$clog2(numChannels)-1:0] arb_chan_id_t;

  // Request/response bundles towards the SRAM macro controller
  typedef struct packed {
    logic                       rq_valid;
    logic                       rq_wr;
    logic [$clog2(numRows)-1:0] addr;
    logic [numCols-1:0]         wr_data;
  } to_sram_t;

  typedef struct packed {
    logic               rq_ready;
    logic               rd_valid;
    logic [numCols-1:0] rd_data;
  } from_sram_t;

  // Channel after g in round-robin order, wrapping at n
  function automatic int rr_next(int g, int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/qracc_tag_fifo.sv
// rtl/qracc_tag_fifo.sv - synchronous tag FIFO with underflow pulse
module qracc_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o,
  output logic             underflow_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == (PW+1)'(DEPTH));
  assign head_o      = mem_q[rd_q];
  assign underflow_o = pop_i && empty_o;
  assign do_pop      = pop_i && !empty_o;
  // A push into a full FIFO only lands when a pop frees a slot the same cycle
  assign do_push     = push_i && (!full_o || do_pop);

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/qracc_sram_arbiter.sv
// rtl/qracc_sram_arbiter.sv - N-channel round-robin SRAM front end; optional QRACC_ARB_LOCK_EN grant lock
module qracc_sram_arbiter #(
  parameter int numChannels    = qracc_pkg::numChannels,
  parameter int numRows        = qracc_pkg::numRows,
  parameter int numCols        = qracc_pkg::numCols,
  parameter int maxOutstanding = qracc_pkg::maxOutstanding
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [numChannels-1:0]                 ch_rq_valid_i,
  input  logic [numChannels-1:0]                 ch_rq_wr_i,
  input  logic [numChannels*$clog2(numRows)-1:0] ch_addr_i,
  input  logic [numChannels*numCols-1:0]         ch_wr_data_i,
`ifdef QRACC_ARB_LOCK_EN
  input  logic [numChannels-1:0]                 ch_lock_i,
`endif
  output logic [numChannels-1:0]                 ch_rq_ready_o,
  output logic [numChannels-1:0]                 ch_rd_valid_o,
  output logic [numCols-1:0]                     ch_rd_data_o,
  output logic                                   sram_rq_valid_o,
  output logic                                   sram_rq_wr_o,
  output logic [$clog2(numRows)-1:0]             sram_addr_o,
  output logic [numCols-1:0]                     sram_wr_data_o,
  input  logic                                   sram_rq_ready_i,
  input  logic                                   sram_rd_valid_i,
  input  logic [numCols-1:0]                     sram_rd_data_i,
  output logic                                   err_o
);

  import qracc_pkg::*;

  localparam int AW = $clog2(numRows);
  localparam int CW = $clog2(numChannels);

  logic [numChannels-1:0] eligible, rd_valid_d, rd_valid_q;
  logic [CW-1:0]          ptr_q, ptr_d, gnt, fifo_head;
  logic [numCols-1:0]     rd_data_q;
  logic                   any_elig, accept, pop_ok, err_q;
  logic                   fifo_full, fifo_empty, fifo_underflow;
`ifdef QRACC_ARB_LOCK_EN
  logic                   lock_q, lock_d;
  logic [CW-1:0]          lock_ch_q, lock_ch_d;
`endif

  assign pop_ok = sram_rd_valid_i && !fifo_empty;

  // Eligibility: reads need a free tag slot (or one freed this cycle); a held lock masks everyone else
  always_comb begin
    eligible = '0;
    for (int i = 0; i < numChannels; i++) begin
      eligible[i] = ch_rq_valid_i[i] && (ch_rq_wr_i[i] || !fifo_full || pop_ok);
    end
`ifdef QRACC_ARB_LOCK_EN
    if (lock_q && ch_rq_valid_i[lock_ch_q]) begin
      for (int i = 0; i < numChannels; i++) begin
        if (CW'(i) != lock_ch_q) eligible[i] = 1'b0;
      end
    end
`endif
    if (rst) eligible = '0;
  end

  // Grant: first eligible channel at or after the pointer, wrapping around
  always_comb begin
    any_elig = 1'b0;
    gnt      = ptr_q;
    for (int k = 0; k < numChannels; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= numChannels) idx = idx - numChannels;
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        gnt      = CW'(idx);
      end
    end
  end

  assign accept          = any_elig && sram_rq_ready_i;
  assign sram_rq_valid_o = any_elig;
  assign sram_rq_wr_o    = any_elig && ch_rq_wr_i[gnt];
  assign sram_addr_o     = any_elig ? ch_addr_i[gnt*AW +: AW] : '0;
  assign sram_wr_data_o  = any_elig ? ch_wr_data_i[gnt*numCols +: numCols] : '0;

  // Ready is a pass-through of the slave ready, steered to the granted channel only
  always_comb begin
    ch_rq_ready_o = '0;
    for (int i = 0; i < numChannels; i++) begin
      ch_rq_ready_o[i] = accept && (gnt == CW'(i));
    end
  end

  // Next pointer (and lock state); a locked accept keeps the pointer on the holder
  always_comb begin
    ptr_d = ptr_q;
`ifdef QRACC_ARB_LOCK_EN
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (lock_q && !ch_rq_valid_i[lock_ch_q]) lock_d = 1'b0;
    if (accept) begin
      if (ch_lock_i[gnt]) begin
        lock_d    = 1'b1;
        lock_ch_d = gnt;
      end else begin
        lock_d = 1'b0;
        ptr_d  = CW'(rr_next(int'(gnt), numChannels));
      end
    end
`else
    if (accept) ptr_d = CW'(rr_next(int'(gnt), numChannels));
`endif
  end

  // One-hot response strobe for the channel at the head of the tag FIFO
  always_comb begin
    rd_valid_d = '0;
    for (int i = 0; i < numChannels; i++) begin
      rd_valid_d[i] = pop_ok && (fifo_head == CW'(i));
    end
  end

  qracc_tag_fifo #(
    .WIDTH (CW),
    .DEPTH (maxOutstanding)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept && !ch_rq_wr_i[gnt]),
    .data_i      (gnt),
    .pop_i       (sram_rd_valid_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head),
    .underflow_o (fifo_underflow)
  );

  // Registered state: pointer, response register and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
`ifdef QRACC_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_ch_q  <= '0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
      if (pop_ok) rd_data_q <= sram_rd_data_i;
      err_q      <= err_q || fifo_underflow;
`ifdef QRACC_ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_ch_q  <= lock_ch_d;
`endif
    end
  end

  assign ch_rd_valid_o = rd_valid_q;
  assign ch_rd_data_o  = rd_data_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// tb/tb_qracc_sram_arbiter.sv - directed self-checking bench for qracc_sram_arbiter
module tb_qracc_sram_arbiter;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_rq_valid_i, ch_rq_wr_i;
  logic [N*AW-1:0] ch_addr_i;
  logic [N*DW-1:0] ch_wr_data_i;
  logic [N-1:0]    ch_lock_i;
  logic [N-1:0]    ch_rq_ready_o, ch_rd_valid_o;
  logic [DW-1:0]   ch_rd_data_o;
  logic            sram_rq_valid_o, sram_rq_wr_o;
  logic [AW-1:0]   sram_addr_o;
  logic [DW-1:0]   sram_wr_data_o;
  logic            sram_rq_ready_i, sram_rd_valid_i;
  logic [DW-1:0]   sram_rd_data_i;
  logic            err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  qracc_sram_arbiter #(
    .numChannels    (N),
    .numRows        (128),
    .numCols        (DW),
    .maxOutstanding (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ch_rq_valid_i   (ch_rq_valid_i),
    .ch_rq_wr_i      (ch_rq_wr_i),
    .ch_addr_i       (ch_addr_i),
    .ch_wr_data_i    (ch_wr_data_i),
`ifdef QRACC_ARB_LOCK_EN
    .ch_lock_i       (ch_lock_i),
`endif
    .ch_rq_ready_o   (ch_rq_ready_o),
    .ch_rd_valid_o   (ch_rd_valid_o),
    .ch_rd_data_o    (ch_rd_data_o),
    .sram_rq_valid_o (sram_rq_valid_o),
    .sram_rq_wr_o    (sram_rq_wr_o),
    .sram_addr_o     (sram_addr_o),
    .sram_wr_data_o  (sram_wr_data_o),
    .sram_rq_ready_i (sram_rq_ready_i),
    .sram_rd_valid_i (sram_rd_valid_i),
    .sram_rd_data_i  (sram_rd_data_i),
    .err_o           (err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ch_rq_valid_i   = '0;
    ch_rq_wr_i      = '0;
    ch_addr_i       = '0;
    ch_wr_data_i    = '0;
    ch_lock_i       = '0;
    sram_rq_ready_i = 1'b1;
    sram_rd_valid_i = 1'b0;
    sram_rd_data_i  = '0;
  endtask

  task automatic set_ch(input int c, input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_rq_valid_i[c]         = v;
    ch_rq_wr_i[c]            = w;
    ch_addr_i[c*AW +: AW]    = a;
    ch_wr_data_i[c*DW +: DW] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    set_ch(0, 1'b1, 1'b1, 7'd3, 32'h1);
    tick();
    total++;
    if (sram_rq_valid_o !== 1'b0 || ch_rq_ready_o !== 4'b0000) begin
      bad++;
      $display("FAIL reset_req: sram_rq_valid=%b ready=%b required 0/0000", sram_rq_valid_o, ch_rq_ready_o);
    end
    tick();
    total++;
    if (err_o !== 1'b0 || ch_rd_valid_o !== 4'b0000 || ch_rd_data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_state: err=%b rd_valid=%b rd_data=%h required 0/0000/0", err_o, ch_rd_valid_o, ch_rd_data_o);
    end
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    set_ch(1, 1'b1, 1'b0, 7'd5, 32'h0);
    #1;
    total++;
    if (ch_rq_ready_o !== 4'b0010 || sram_rq_valid_o !== 1'b1 || sram_rq_wr_o !== 1'b0 || sram_addr_o !== 7'd5) begin
      bad++;
      $display("FAIL single_req: ready=%b valid=%b wr=%b addr=%0d required 0010/1/0/5", ch_rq_ready_o, sram_rq_valid_o, sram_rq_wr_o, sram_addr_o);
    end
    tick();
    set_ch(1, 1'b0, 1'b0, 7'd0, 32'h0);
    tick();
    tick();
    sram_rd_valid_i = 1'b1;
    sram_rd_data_i  = 32'hDEADBEEF;
    #1;
    total++;
    if (ch_rd_valid_o !== 4'b0000) begin
      bad++;
      $display("FAIL single_early: rd_valid=%b required 0000", ch_rd_valid_o);
    end
    tick();
    sram_rd_valid_i = 1'b0;
    total++;
    if (ch_rd_valid_o !== 4'b0010 || ch_rd_data_o !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_resp: rd_valid=%b data=%h required 0010/deadbeef", ch_rd_valid_o, ch_rd_data_o);
    end
    tick();
    total++;
    if (ch_rd_valid_o !== 4'b0000 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL single_after: rd_valid=%b err=%b required 0000/0", ch_rd_valid_o, err_o);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_gnt [5];
    logic [AW-1:0] exp_addr [5];
    exp_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_addr = '{7'd10, 7'd11, 7'd12, 7'd13, 7'd10};
    do_reset();
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b1, AW'(10 + c), DW'(32'h100 + c));
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (ch_rq_ready_o !== exp_gnt[k] || sram_addr_o !== exp_addr[k] || sram_rq_wr_o !== 1'b1) begin
        bad++;
        $display("FAIL fairness[%0d]: ready=%b addr=%0d wr=%b required %b/%0d/1", k, ch_rq_ready_o, sram_addr_o, sram_rq_wr_o, exp_gnt[k], exp_addr[k]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    logic [N-1:0] exp_drain [4];
    exp_drain = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
    do_reset();
    set_ch(0, 1'b1, 1'b0, 7'd1, 32'h0);
    for (int k = 0; k < 4; k++) tick();
    set_ch(0, 1'b0, 1'b0, 7'd0, 32'h0);
    set_ch(2, 1'b1, 1'b0, 7'd22, 32'h0);
    set_ch(3, 1'b1, 1'b1, 7'd33, 32'hCAFE);
    #1;
    total++;
    if (ch_rq_ready_o !== 4'b1000 || sram_rq_wr_o !== 1'b1 || sram_addr_o !== 7'd33 || sram_wr_data_o !== 32'hCAFE) begin
      bad++;
      $display("FAIL full_write: ready=%b wr=%b addr=%0d data=%h required 1000/1/33/cafe", ch_rq_ready_o, sram_rq_wr_o, sram_addr_o, sram_wr_data_o);
    end
    tick();
    set_ch(3, 1'b0, 1'b0, 7'd0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      #1;
      total++;
      if (ch_rq_ready_o !== 4'b0000 || sram_rq_valid_o !== 1'b0) begin
        bad++;
        $display("FAIL full_stall[%0d]: ready=%b valid=%b required 0000/0", k, ch_rq_ready_o, sram_rq_valid_o);
      end
      tick();
    end
    sram_rd_valid_i = 1'b1;
    sram_rd_data_i  = 32'h11;
    #1;
    total++;
    if (ch_rq_ready_o !== 4'b0100) begin
      bad++;
      $display("FAIL full_pop_accept: ready=%b required 0100", ch_rq_ready_o);
    end
    tick();
    set_ch(2, 1'b0, 1'b0, 7'd0, 32'h0);
    total++;
    if (ch_rd_valid_o !== 4'b0001 || ch_rd_data_o !== 32'h11) begin
      bad++;
      $display("FAIL full_first_resp: rd_valid=%b data=%h required 0001/11", ch_rd_valid_o, ch_rd_data_o);
    end
    for (int k = 0; k < 4; k++) begin
      sram_rd_data_i = DW'(32'h20 + k);
      tick();
      total++;
      if (ch_rd_valid_o !== exp_drain[k] || ch_rd_data_o !== DW'(32'h20 + k)) begin
        bad++;
        $display("FAIL full_drain[%0d]: rd_valid=%b data=%h required %b/%h", k, ch_rd_valid_o, ch_rd_data_o, exp_drain[k], 32'h20 + k);
      end
    end
    sram_rd_valid_i = 1'b0;
    tick();
    total++;
    if (err_o !== 1'b0 || ch_rd_valid_o !== 4'b0000) begin
      bad++;
      $display("FAIL full_end: err=%b rd_valid=%b required 0/0000", err_o, ch_rd_valid_o);
    end
  endtask

  task automatic test_ordering();
    logic [N-1:0]  exp_v [3];
    logic [DW-1:0] exp_d [3];
    int            order [3];
    exp_v = '{4'b1000, 4'b0001, 4'b0100};
    exp_d = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};
    order = '{3, 0, 2};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_ch(order[k], 1'b1, 1'b0, AW'(40 + k), 32'h0);
      tick();
      set_ch(order[k], 1'b0, 1'b0, 7'd0, 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      sram_rd_valid_i = 1'b1;
      sram_rd_data_i  = exp_d[k];
      tick();
      total++;
      if (ch_rd_valid_o !== exp_v[k] || ch_rd_data_o !== exp_d[k]) begin
        bad++;
        $display("FAIL order[%0d]: rd_valid=%b data=%h required %b/%h", k, ch_rd_valid_o, ch_rd_data_o, exp_v[k], exp_d[k]);
      end
    end
    sram_rd_valid_i = 1'b0;
    tick();
    total++;
    if (ch_rd_valid_o !== 4'b0000 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL order_end: rd_valid=%b err=%b required 0000/0", ch_rd_valid_o, err_o);
    end
  endtask

  task automatic test_error();
    do_reset();
    sram_rd_valid_i = 1'b1;
    sram_rd_data_i  = 32'h55;
    #1;
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_before: err=%b required 0", err_o);
    end
    tick();
    sram_rd_valid_i = 1'b0;
    total++;
    if (err_o !== 1'b1 || ch_rd_valid_o !== 4'b0000) begin
      bad++;
      $display("FAIL err_set: err=%b rd_valid=%b required 1/0000", err_o, ch_rd_valid_o);
    end
    tick();
    tick();
    total++;
    if (err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_sticky: err=%b required 1", err_o);
    end
    // push and invalid pop together on an empty FIFO: the push must survive
    set_ch(1, 1'b1, 1'b0, 7'd9, 32'h0);
    sram_rd_valid_i = 1'b1;
    tick();
    set_ch(1, 1'b0, 1'b0, 7'd0, 32'h0);
    sram_rd_valid_i = 1'b0;
    total++;
    if (ch_rd_valid_o !== 4'b0000) begin
      bad++;
      $display("FAIL err_pushpop: rd_valid=%b required 0000", ch_rd_valid_o);
    end
    sram_rd_valid_i = 1'b1;
    sram_rd_data_i  = 32'h77;
    tick();
    sram_rd_valid_i = 1'b0;
    total++;
    if (ch_rd_valid_o !== 4'b0010 || ch_rd_data_o !== 32'h77) begin
      bad++;
      $display("FAIL err_push_kept: rd_valid=%b data=%h required 0010/77", ch_rd_valid_o, ch_rd_data_o);
    end
    do_reset();
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_clear: err=%b required 0", err_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ch(0, 1'b1, 1'b0, 7'd1, 32'h0);
    set_ch(1, 1'b1, 1'b0, 7'd2, 32'h0);
    tick();
    tick();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sram_rd_valid_i = 1'b1;
    sram_rd_data_i  = 32'h99;
    tick();
    sram_rd_valid_i = 1'b0;
    total++;
    if (ch_rd_valid_o !== 4'b0000 || err_o !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_stray: rd_valid=%b err=%b required 0000/1", ch_rd_valid_o, err_o);
    end
    for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b1, AW'(c), 32'h0);
    #1;
    total++;
    if (ch_rq_ready_o !== 4'b0001) begin
      bad++;
      $display("FAIL rstmid_ptr: ready=%b required 0001", ch_rq_ready_o);
    end
    clear_inputs();
    tick();
  endtask

`ifdef QRACC_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    set_ch(0, 1'b1, 1'b1, 7'd0, 32'h0);
    tick();
    set_ch(1, 1'b1, 1'b1, 7'd1, 32'h0);
    set_ch(2, 1'b1, 1'b1, 7'd2, 32'h0);
    ch_lock_i[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (ch_rq_ready_o !== 4'b0010) begin
        bad++;
        $display("FAIL lock_hold[%0d]: ready=%b required 0010", k, ch_rq_ready_o);
      end
      tick();
    end
    set_ch(1, 1'b0, 1'b0, 7'd0, 32'h0);
    ch_lock_i[1] = 1'b0;
    #1;
    total++;
    if (ch_rq_ready_o !== 4'b0100) begin
      bad++;
      $display("FAIL lock_release: ready=%b required 0100", ch_rq_ready_o);
    end
    clear_inputs();
    tick();
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_single_read();
    test_fairness();
    test_fifo_full();
    test_ordering();
    test_error();
    test_reset_mid();
`ifdef QRACC_ARB_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qracc_sram_arbiter.md
Name: qracc_sram_arbiter

Overview:
- Parametrised N-channel front end for one QRAcc SRAM macro controller. Generalises the single-master SRAM request/response handshake to numChannels requesters, with round-robin arbitration, bounded outstanding reads and in-order read-response routing.
- Sits between the feature loader, activation buffer and config/debug masters and the SRAM controller slave port.

Parameters:
- numChannels, 4, number of requesting masters (≥2)
- numRows, 128, SRAM rows; address width is $clog2(numRows)
- numCols, 32, SRAM data width
- maxOutstanding, 4, read-tag FIFO depth (power of 2, ≥2)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- ch_rq_valid_i  in  numChannels  per-channel request valid
- ch_rq_wr_i  in  numChannels  per-channel write(1)/read(0)
- ch_addr_i  in  numChannels*$clog2(numRows)  flattened addresses; channel i at slice i
- ch_wr_data_i  in  numChannels*numCols  flattened write data
- ch_rq_ready_o  out  numChannels  request accepted when valid&ready
- ch_rd_valid_o  out  numChannels  one-hot read-response strobe
- ch_rd_data_o  out  numCols  read data, broadcast; qualified by ch_rd_valid_o
- sram_rq_valid_o, sram_rq_wr_o, sram_addr_o, sram_wr_data_o  out  1/1/$clog2(numRows)/numCols  to SRAM controller
- sram_rq_ready_i, sram_rd_valid_i  in  1/1  from SRAM controller
- sram_rd_data_i  in  numCols  read data
- err_o  out  1  sticky: read response with empty tag FIFO

Behaviour:
- Reset (rst high at posedge):
  - RR pointer=0, tag FIFO empty, err_o=0.
  - All *_o low or zero; sram_* outputs zero; ch_rd_data_o=0.
  - Any in-flight responses are forgotten.
- Eligibility: ch i is eligible when ch_rq_valid_i[i] && (ch_rq_wr_i[i] || !fifo_full || fifo_pop_this_cycle).
  - When the FIFO is full, reads stall but writes still arbitrate.
- Grant (combinational): first eligible channel scanning from the RR pointer upward, with wrap-around.
  - sram_rq_valid_o=|eligible.
  - sram_* request fields are muxed from the granted channel.
- ch_rq_ready_o[g] = sram_rq_ready_i for the granted channel only; all other ready bits are 0.
  - Zero-cycle pass-through: no request register.
  - Masters must hold valid and payload until ready.
- Accept (sram_rq_valid_o && sram_rq_ready_i):
  - RR pointer becomes (g+1) mod numChannels on the next cycle.
  - No accept means the pointer holds.
- On an accepted read, push channel id g into the tag FIFO.
- Read response (sram_rd_valid_i):
  - Pop the FIFO head h.
  - ch_rd_valid_o is registered: one-hot bit h asserts the cycle after sram_rd_valid_i.
  - ch_rd_data_o is registered from sram_rd_data_i alongside it.
  - Latency from SRAM response to channel response is 1 cycle.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- Simultaneous push and pop on an empty FIFO:
  - The pop is invalid, so err_o sets.
  - The push still completes.
  - No ch_rd_valid_o is produced.
- sram_rd_valid_i with an empty FIFO:
  - err_o=1 (sticky until rst).
  - Response dropped; no ch_rd_valid_o.
- Responses are strictly in accept order; the SRAM controller is required to return reads in order.
- Writes produce no response and no FIFO entry.

Optional Feature:
- Macro: QRACC_ARB_LOCK_EN
- With the macro, port ch_lock_i (in, numChannels) is added.
  - If the granted channel has ch_lock_i high at accept, the grant is held on that channel.
  - The pointer does not advance, and other channels are masked, until an accept with lock low or until that channel drops valid.
  - Used for atomic multi-row weight bursts.
- Without the macro: no port, pure round-robin.

Decomposition:
- qracc_pkg additions:
  - arbiter parameters numChannels and maxOutstanding.
  - typedef arb_chan_id_t = logic [$clog2(numChannels)-1:0].
  - Reuse of to_sram_t/from_sram_t field naming.
- Sub-module qracc_tag_fifo: synchronous FIFO, parametrised width and depth, ports push/pop/full/empty/head.
  - A pop on empty is ignored and reported via an underflow pulse, which drives err_o.

Test Plan:
- Single channel: ch1 reads addr 5, SRAM answers 0xDEADBEEF after 3 cycles → ch_rd_valid_o=4'b0010 one cycle after sram_rd_valid_i; ch_rd_data_o=0xDEADBEEF.
- Fairness: all 4 channels hold valid with sram_rq_ready_i=1 → grants 0,1,2,3,0 on consecutive cycles; no channel starves.
- FIFO full: 4 reads accepted with no response, then ch2 read plus ch3 write pending → ch3 write accepted; ch2 ready stays 0 until sram_rd_valid_i, then accepted that same cycle.
- Ordering: reads from ch3, ch0, ch2 accepted, then 3 responses A, B, C → ch_rd_valid_o sequence 1000, 0001, 0100 with data A, B, C.
- Error: sram_rd_valid_i while FIFO empty → err_o rises next cycle and stays 1; no ch_rd_valid_o; cleared only by rst.
- Reset mid-operation: rst with 2 reads outstanding, then 1 stray response → no ch_rd_valid_o; err_o=1; pointer restarts at channel 0.
- Under QRACC_ARB_LOCK_EN, ch1 with lock high for 3 accepts → 3 consecutive ch1 grants while ch0 and ch2 wait.
